// File: rtl/core_pkg.sv
// Shared definitions for the core front end and execute stage: ALU codes,
// instruction encodings, instruction field positions and the fetch FSM states.
package core_pkg;

  // ALU operation codes; the ALU decodes the same values
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [6:0]  OPC_RTYPE   = 7'b0110011;
  localparam logic [31:0] INSTR_ECALL = 32'h0000_0073;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

  // Instruction field positions (LSB of each field)
  localparam int unsigned OPC_LSB    = 0;
  localparam int unsigned RD_LSB     = 7;
  localparam int unsigned FUNCT3_LSB = 12;
  localparam int unsigned RS1_LSB    = 15;
  localparam int unsigned RS2_LSB    = 20;
  localparam int unsigned FUNCT7_LSB = 25;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_ERROR = 2'd2
  } state_e;

endpackage

// File: rtl/instr_decoder.sv
// Combinational RV32I R-type decoder: extracts register indices, selects the
// ALU code and flags legal ALU ops and ECALL.
module instr_decoder
  import core_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [4:0]  rd_o,
  output logic [3:0]  alu_control_o,
  output logic        legal_o,
  output logic        is_ecall_o
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;

  assign opcode     = instr_i[OPC_LSB +: 7];
  assign funct3     = instr_i[FUNCT3_LSB +: 3];
  assign funct7     = instr_i[FUNCT7_LSB +: 7];
  assign rs1_o      = instr_i[RS1_LSB +: 5];
  assign rs2_o      = instr_i[RS2_LSB +: 5];
  assign rd_o       = instr_i[RD_LSB +: 5];
  assign is_ecall_o = (instr_i == INSTR_ECALL);

  // Map funct7/funct3 of an R-type word onto the ALU code
  always_comb begin
    alu_control_o = ALU_AND;
    legal_o       = 1'b0;
    if (opcode == OPC_RTYPE) begin
      case ({funct7, funct3})
        {F7_BASE, F3_ADDSUB}: begin alu_control_o = ALU_ADD; legal_o = 1'b1; end
        {F7_ALT,  F3_ADDSUB}: begin alu_control_o = ALU_SUB; legal_o = 1'b1; end
        {F7_BASE, F3_AND}:    begin alu_control_o = ALU_AND; legal_o = 1'b1; end
        {F7_BASE, F3_OR}:     begin alu_control_o = ALU_OR;  legal_o = 1'b1; end
        {F7_BASE, F3_SLT}:    begin alu_control_o = ALU_SLT; legal_o = 1'b1; end
        default:              begin alu_control_o = ALU_AND; legal_o = 1'b0; end
      endcase
    end
  end

endmodule

// File: rtl/fetch_decode.sv
// Core front end: credit-limited instruction fetch into a 2-entry FIFO,
// combinational decode of the head and a valid/ready bundle toward execute.
// ECALL halts and an illegal word traps; both freeze fetch until reset.
module fetch_decode
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [3:0]  alu_control,
  output logic        write_en,
  output logic        halted,
  output logic        error,
  output logic [31:0] retired
);

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] retired_q;
  logic        inflight_q;
  logic        halted_q;
  logic        error_q;
  logic [1:0]  count_q;
  logic        rd_ptr_q;
  logic        wr_ptr_q;
  logic [31:0] buf_q [BUF_DEPTH];

  logic        run, buffered, push, have_head, store, unload;
  logic        accept, flush, head_ecall, head_illegal, credit_ok;
  logic [31:0] head;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic [3:0]  dec_alu;
  logic        dec_legal, dec_ecall;

  assign run       = (state_q == ST_RUN) && !reset;
  assign buffered  = (count_q != '0);
  assign push      = run && inflight_q;
  assign have_head = buffered || push;

  // With an empty buffer the arriving word is decoded directly so it can
  // issue in the cycle it lands; it is only stored if not accepted.
  assign head = buffered ? buf_q[rd_ptr_q] : imem_rdata;

  instr_decoder u_dec (
    .instr_i       (head),
    .rs1_o         (dec_rs1),
    .rs2_o         (dec_rs2),
    .rd_o          (dec_rd),
    .alu_control_o (dec_alu),
    .legal_o       (dec_legal),
    .is_ecall_o    (dec_ecall)
  );

  assign head_ecall   = run && have_head && dec_ecall;
  assign head_illegal = run && have_head && !dec_legal && !dec_ecall;
  assign flush        = head_ecall || head_illegal;

  assign out_valid = run && have_head && dec_legal;
  assign accept    = out_valid && out_ready;
  assign write_en  = accept && (dec_rd != '0);

  assign rs1         = out_valid ? dec_rs1 : '0;
  assign rs2         = out_valid ? dec_rs2 : '0;
  assign rd          = out_valid ? dec_rd  : '0;
  assign alu_control = out_valid ? dec_alu : '0;

  assign credit_ok = ({1'b0, count_q} + {2'b00, inflight_q}) < 3'(BUF_DEPTH);
  assign imem_req  = run && credit_ok && !flush;
  assign imem_addr = pc_q;

  assign store  = push && !(accept && !buffered);
  assign unload = accept && buffered;

  assign halted  = halted_q;
  assign error   = error_q;
  assign retired = retired_q;

  // Instruction buffer storage (data path, no reset needed)
  always_ff @(posedge clk) begin
    if (!reset && !flush && store) begin
      buf_q[wr_ptr_q] <= imem_rdata;
    end
  end

  // Fetch pointer, credit, FIFO pointers, retire counter and halt/trap FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      retired_q  <= '0;
      halted_q   <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      if (imem_req) begin
        pc_q <= pc_q + 32'd4;
      end
      inflight_q <= imem_req;
      if (flush) begin
        count_q  <= '0;
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
      end else begin
        if (store) begin
          wr_ptr_q <= ~wr_ptr_q;
        end
        if (unload) begin
          rd_ptr_q <= ~rd_ptr_q;
        end
        count_q <= count_q + 2'(store) - 2'(unload);
      end
      if (accept) begin
        retired_q <= retired_q + 32'd1;
      end
      unique case (state_q)
        ST_RUN: begin
          if (head_ecall) begin
            state_q  <= ST_HALT;
            halted_q <= 1'b1;
          end else if (head_illegal) begin
            state_q <= ST_ERROR;
            error_q <= 1'b1;
          end
        end
        ST_HALT, ST_ERROR: begin
          state_q <= state_q;
        end
        default: begin
          state_q <= ST_ERROR;
        end
      endcase
    end
  end

  // The fetch credit must make a push into a full buffer impossible
  always_ff @(posedge clk) begin
    if (!reset && !flush && store) begin
      assert (count_q < 2'(BUF_DEPTH));
    end
  end

endmodule
